// File: rtl/pixel_write_sink.sv
// Framebuffer write sink: accepts pixel plots over valid/ready, clips off-screen
// coordinates, queues them and issues one framebuffer write per cycle when the RAM port is free.
module pixel_write_sink #(
  parameter int H_RES      = 160,
  parameter int V_RES      = 120,
  parameter int COLOR_W    = 12,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               plot,
  output logic               plot_ready,
  input  logic [7:0]         x,
  input  logic [7:0]         y,
  input  logic [COLOR_W-1:0] color,
  input  logic               fb_stall,
  output logic               fb_wren,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  output logic               busy,
  output logic [15:0]        drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [8:0]        H_LIM   = 9'(H_RES);
  localparam logic [8:0]        V_LIM   = 9'(V_RES);
  localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

  logic [7:0]         mem_x [FIFO_DEPTH];
  logic [7:0]         mem_y [FIFO_DEPTH];
  logic [COLOR_W-1:0] mem_c [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;

  logic accept;
  logic on_screen;
  logic push;
  logic pop;
  logic drop;

  // Ready comes only from the registered count, so a pop never frees a slot in the same cycle.
  always_comb begin
    plot_ready = !reset && (count < DEPTH_C);
    accept     = plot && plot_ready;
    on_screen  = ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
    push       = accept && on_screen;
    drop       = accept && !on_screen;
    pop        = (count != '0) && !fb_stall;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr] <= x;
      mem_y[wr_ptr] <= y;
      mem_c[wr_ptr] <= color;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fb_wren <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else if (pop) begin
      fb_wren <= 1'b1;
      fb_addr <= ADDR_W'(mem_y[rd_ptr]) * H_RES_A + ADDR_W'(mem_x[rd_ptr]);
      fb_data <= mem_c[rd_ptr];
    end else begin
      fb_wren <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  assign busy = (count != '0) || fb_wren;

endmodule
